framebuf_arbiter: RTL and testbench

Single-port framebuffer access arbiter in the vga_clk_25 domain, directly upstream of the VGA scan-out controller. The VGA controller's reads have absolute priority and fixed 1-cycle latency. Pixel writes from the capture path, already synchronised to vga_clk_25, are buffered in a small FIFO. They drain to the RAM only on cycles with no read (blanking and off-framebuffer regions).

---
 rtl/osiris_fb_pkg.sv | 13 +
 rtl/fb_write_fifo.sv | 46 ++++
 rtl/framebuf_arbiter.sv | 101 ++++++++++
 tb/tb_framebuf_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/osiris_fb_pkg.sv
// Framebuffer geometry and write-entry type shared by the arbiter and the VGA controller.
package osiris_fb_pkg;
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_W    = 17;
  localparam int PIX_W     = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } wr_entry_t;
endpackage

// File: rtl/fb_write_fifo.sv
// Synchronous FIFO with registered level and a head entry valid while non-empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module fb_write_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 19
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q, level_q;
  logic         push_ok, pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

  // Pointers carry an extra wrap bit; occupancy is tracked separately in level_q.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/framebuf_arbiter.sv
// Single-port framebuffer arbiter: VGA reads win every cycle, buffered capture writes
// drain on read-free cycles; tracks out-of-bounds writes and write starvation.
module framebuf_arbiter
  import osiris_fb_pkg::*;
#(
  parameter int ADDR_W       = osiris_fb_pkg::ADDR_W,
  parameter int PIX_W        = osiris_fb_pkg::PIX_W,
  parameter int FB_DEPTH     = osiris_fb_pkg::FB_DEPTH,
  parameter int FIFO_DEPTH   = 8,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic                          vga_clk_25,
  input  logic                          reset_n,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [PIX_W-1:0]              rd_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [PIX_W-1:0]              wr_data,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_we,
  output logic [PIX_W-1:0]              ram_wdata,
  input  logic [PIX_W-1:0]              ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_oob,
  output logic                          err_starve
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wr_entry_t     push_ent, head_ent;
  logic          full, empty, in_bounds, push, pop;
  logic          rd_pend_q;
  logic [PIX_W-1:0] hold_q;
  logic          err_oob_q, err_oob_d, err_starve_q, err_starve_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  assign in_bounds     = {1'b0, wr_addr} < (ADDR_W+1)'(FB_DEPTH);
  assign wr_ready      = !full;
  assign push          = wr_valid && !full && in_bounds;
  // Gating with reset_n keeps a queued write from reaching the RAM on the reset cycle.
  assign pop           = reset_n && !rd_en && !empty;
  assign push_ent.addr = wr_addr;
  assign push_ent.data = wr_data;

  fb_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(wr_entry_t))
  ) u_fifo (
    .clk_i      (vga_clk_25),
    .reset_n_i  (reset_n),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .head_o     (head_ent),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (fifo_level)
  );

  always_comb begin
    ram_addr  = rd_addr;
    ram_we    = 1'b0;
    ram_wdata = head_ent.data;
    if (pop) begin
      ram_addr = head_ent.addr;
      ram_we   = 1'b1;
    end
  end

  assign rd_data = rd_pend_q ? ram_rdata : hold_q;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (empty || pop)
      starve_cnt_d = '0;
    else if (rd_en && starve_cnt_q != CW'(STARVE_LIMIT))
      starve_cnt_d = starve_cnt_q + 1'b1;
    err_starve_d = err_starve_q || (starve_cnt_d == CW'(STARVE_LIMIT));
    err_oob_d    = err_oob_q || (wr_valid && !full && !in_bounds);
  end

  always_ff @(posedge vga_clk_25) begin
    if (!reset_n) begin
      rd_pend_q    <= 1'b0;
      hold_q       <= '0;
      err_oob_q    <= 1'b0;
      err_starve_q <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      rd_pend_q    <= rd_en;
      hold_q       <= rd_data;
      err_oob_q    <= err_oob_d;
      err_starve_q <= err_starve_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign err_oob    = err_oob_q;
  assign err_starve = err_starve_q;
endmodule

// File: tb/tb_framebuf_arbiter.sv
// Scoreboard bench for framebuf_arbiter against a 1-cycle synchronous RAM model.
module tb_framebuf_arbiter;
  localparam int AW = 17;
  localparam int PW = 2;
  localparam int DEPTH = 76800;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [PW-1:0] rd_data;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [PW-1:0] wr_data = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [PW-1:0] ram_wdata;
  logic [PW-1:0] ram_rdata = '0;
  logic [3:0]    fifo_level;
  logic          err_oob, err_starve;

  framebuf_arbiter #(
    .ADDR_W(AW), .PIX_W(PW), .FB_DEPTH(DEPTH), .FIFO_DEPTH(8), .STARVE_LIMIT(16)
  ) dut (
    .vga_clk_25(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .fifo_level(fifo_level), .err_oob(err_oob),
    .err_starve(err_starve)
  );

  always #20 clk = ~clk;

  logic [PW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0]      rq[$];
  logic [AW+PW-1:0]   wq[$];
  logic               rd_pend_tb = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) rd_pend_tb <= reset_n ? rd_en : 1'b0;

  // Scoreboard monitor: read returns and RAM writes, compared mid-cycle.
  always @(negedge clk) begin
    logic [AW+PW-1:0] e;
    if (rd_pend_tb && rq.size() > 0) check_eq("rd_data", 32'(rd_data), 32'(rq.pop_front()));
    if (rd_en) begin
      check_eq("rd_ram_addr", 32'(ram_addr), 32'(rd_addr));
      check_eq("rd_ram_we", 32'(ram_we), 32'd0);
    end else if (ram_we) begin
      if (wq.size() == 0) check_eq("ram_we_unexpected", 32'(ram_we), 32'd0);
      else begin
        e = wq.pop_front();
        check_eq("wr_addr", 32'(ram_addr), 32'(e[AW+PW-1:PW]));
        check_eq("wr_data", 32'(ram_wdata), 32'(e[PW-1:0]));
      end
    end
  end

  logic          acc;
  logic [3:0]    lvl_s;
  logic          we_s, rdy_s, oob_s, stv_s;
  logic [PW-1:0] rdd_s;

  task automatic step(input logic r, input logic [AW-1:0] ra, input logic [PW-1:0] rexp,
                      input logic wv, input logic [AW-1:0] wa, input logic [PW-1:0] wd,
                      output logic accepted);
    rd_en = r; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
    if (r) rq.push_back(rexp);
    @(negedge clk);
    lvl_s = fifo_level; we_s = ram_we; rdy_s = wr_ready;
    oob_s = err_oob; stv_s = err_starve; rdd_s = rd_data;
    accepted = wv && wr_ready;
    if (accepted && wa < AW'(DEPTH)) wq.push_back({wa, wd});
    @(posedge clk); #1;
    rd_en = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem[i] = PW'(i);
    @(posedge clk); #1;
    idle(); idle();
    reset_n = 1'b1;
    idle();
    check_eq("rst_level", 32'(lvl_s), 32'd0);
    check_eq("rst_ready", 32'(rdy_s), 32'd1);
    check_eq("rst_we", 32'(we_s), 32'd0);
    check_eq("rst_rd_data", 32'(rdd_s), 32'd0);
    check_eq("rst_oob", 32'(oob_s), 32'd0);
    check_eq("rst_starve", 32'(stv_s), 32'd0);

    // Plain reads of preloaded pixels.
    for (int i = 0; i < 4; i++) step(1'b1, AW'(i), PW'(i), 1'b0, '0, '0, acc);
    idle();

    // Writes held off by reads, then drained.
    for (int i = 0; i < 3; i++) step(1'b1, AW'(3), 2'd3, 1'b1, AW'(10 + i), PW'(i + 1), acc);
    step(1'b1, AW'(3), 2'd3, 1'b0, '0, '0, acc);
    check_eq("t2_level3", 32'(lvl_s), 32'd3);
    check_eq("t2_we_blocked", 32'(we_s), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check_eq("t2_drain_we", 32'(we_s), 32'd1);
      check_eq("t2_hold_rd_data", 32'(rdd_s), 32'd3);
    end
    idle();
    check_eq("t2_level0", 32'(lvl_s), 32'd0);
    check_eq("t2_idle_we", 32'(we_s), 32'd0);
    step(1'b1, AW'(11), 2'd2, 1'b0, '0, '0, acc);
    idle();

    // Fill to full, one pop frees a slot one cycle later.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, AW'(3), 2'd3, 1'b1, AW'(20 + i), PW'(i + 1), acc);
      check_eq("t3_accept", 32'(acc), 32'd1);
    end
    step(1'b1, AW'(3), 2'd3, 1'b1, AW'(28), 2'd3, acc);
    check_eq("t3_full_level", 32'(lvl_s), 32'd8);
    check_eq("t3_full_ready", 32'(rdy_s), 32'd0);
    check_eq("t3_full_block", 32'(acc), 32'd0);
    step(1'b0, '0, '0, 1'b1, AW'(28), 2'd3, acc);
    check_eq("t3_pop_ready", 32'(rdy_s), 32'd0);
    check_eq("t3_pop_we", 32'(we_s), 32'd1);
    step(1'b1, AW'(3), 2'd3, 1'b1, AW'(28), 2'd3, acc);
    check_eq("t3_after_pop_ready", 32'(rdy_s), 32'd1);
    check_eq("t3_9th_accept", 32'(acc), 32'd1);
    check_eq("t3_level7", 32'(lvl_s), 32'd7);
    for (int i = 0; i < 8; i++) idle();
    idle();
    check_eq("t3_level0", 32'(lvl_s), 32'd0);

    // Out-of-bounds write: accepted, discarded, sticky flag.
    step(1'b0, '0, '0, 1'b1, AW'(DEPTH), 2'd3, acc);
    check_eq("t4_accept", 32'(acc), 32'd1);
    check_eq("t4_oob_before", 32'(oob_s), 32'd0);
    idle();
    check_eq("t4_level", 32'(lvl_s), 32'd0);
    check_eq("t4_oob_set", 32'(oob_s), 32'd1);
    check_eq("t4_no_we", 32'(we_s), 32'd0);
    idle(); idle();
    check_eq("t4_oob_sticky", 32'(oob_s), 32'd1);

    // Starvation: one pending write behind 16 read cycles.
    step(1'b1, AW'(3), 2'd3, 1'b1, AW'(40), 2'd2, acc);
    for (int k = 1; k <= 16; k++) step(1'b1, AW'(3), 2'd3, 1'b0, '0, '0, acc);
    check_eq("t5_starve_pre", 32'(stv_s), 32'd0);
    idle();
    check_eq("t5_starve_set", 32'(stv_s), 32'd1);
    check_eq("t5_drain_we", 32'(we_s), 32'd1);
    idle(); idle();
    check_eq("t5_starve_sticky", 32'(stv_s), 32'd1);
    check_eq("t5_level0", 32'(lvl_s), 32'd0);

    // Reset with queued writes: they must never reach the RAM.
    for (int i = 0; i < 5; i++) step(1'b1, AW'(3), 2'd3, 1'b1, AW'(50 + i), PW'(i % 3 + 1), acc);
    wq.delete();
    reset_n = 1'b0;
    idle();
    check_eq("t6_rst_we", 32'(we_s), 32'd0);
    reset_n = 1'b1;
    idle();
    check_eq("t6_level", 32'(lvl_s), 32'd0);
    check_eq("t6_ready", 32'(rdy_s), 32'd1);
    check_eq("t6_rd_data", 32'(rdd_s), 32'd0);
    check_eq("t6_we", 32'(we_s), 32'd0);
    check_eq("t6_oob_clr", 32'(oob_s), 32'd0);
    check_eq("t6_starve_clr", 32'(stv_s), 32'd0);
    idle(); idle();
    for (int i = 0; i < 5; i++) check_eq("t6_mem_untouched", 32'(mem[50 + i]), 32'd0);
    check_eq("rd_queue_left", rq.size(), 0);
    check_eq("wr_queue_left", wq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
